// File: rtl/seg_scan_decoder.sv
// +--------------------------------------------------------------------------+
// | seg_scan_decoder: rebuilds eight hex digits from 7-seg anode/cathode scan |
// | Optional macro SEG_SCAN_ROT_DETECT_EN enables the rotation detector.      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module seg_scan_decoder #(
  parameter int STABLE_CYC = 16,
  parameter int CNT_W      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  anode,
  input  logic [6:0]  cathode,
  output logic [31:0] digits,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        rotated
);

  localparam logic [CNT_W-1:0] C_STABLE      = CNT_W'(STABLE_CYC);
  localparam logic [CNT_W-1:0] C_STABLE_LAST = CNT_W'(STABLE_CYC - 1);

  logic [7:0]       an_s1_q, an_s2_q;
  logic [6:0]       ca_s1_q, ca_s2_q;
  logic [14:0]      prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             latch_q, latch_d;
  logic [31:0]      buf_q, buf_d;
  logic [7:0]       mask_q, mask_d;
  logic [7:0]       err_q, err_d;
  logic [31:0]      digits_q;
  logic             frame_valid_q;
  logic             frame_err_q;

  logic [7:0] w_sel;
  logic       w_one;
  logic       w_chg;
  logic [2:0] w_idx;
  logic       w_cap;
  logic       w_full;
  logic [4:0] w_dec;

  // Returns {undecodable, nibble}; input is the active-high g..a shape.
  function automatic logic [4:0] decode(input logic [6:0] shape);
    logic [4:0] r;
    case (shape)
      7'h3F:   r = 5'h00;
      7'h06:   r = 5'h01;
      7'h5B:   r = 5'h02;
      7'h4F:   r = 5'h03;
      7'h66:   r = 5'h04;
      7'h6D:   r = 5'h05;
      7'h7D:   r = 5'h06;
      7'h07:   r = 5'h07;
      7'h7F:   r = 5'h08;
      7'h6F:   r = 5'h09;
      7'h77:   r = 5'h0A;
      7'h7C:   r = 5'h0B;
      7'h39:   r = 5'h0C;
      7'h5E:   r = 5'h0D;
      7'h79:   r = 5'h0E;
      7'h71:   r = 5'h0F;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  assign w_sel  = ~an_s2_q;
  assign w_one  = (w_sel != 8'h00) && ((w_sel & (w_sel - 8'd1)) == 8'h00);
  assign w_chg  = {an_s2_q, ca_s2_q} != prev_q;
  assign w_cap  = w_one && !w_chg && !latch_q && (cnt_q == C_STABLE_LAST);
  assign w_full = (mask_q == 8'hFF);
  assign w_dec  = decode(~ca_s2_q);

  always_comb begin
    w_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!an_s2_q[i]) w_idx = 3'(i);
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    latch_d = latch_q;
    if (!w_one || w_chg) begin
      cnt_d   = '0;
      latch_d = 1'b0;
    end else if (cnt_q != C_STABLE) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (w_cap) latch_d = 1'b1;

    // Frame load clears mask/errors first so a same-cycle capture lands in the new frame.
    mask_d = w_full ? 8'h00 : mask_q;
    err_d  = w_full ? 8'h00 : err_q;
    buf_d  = buf_q;
    if (w_cap) begin
      mask_d[w_idx]              = 1'b1;
      err_d[w_idx]               = w_dec[4];
      buf_d[{w_idx, 2'b00} +: 4] = w_dec[3:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_s1_q       <= 8'hFF;
      an_s2_q       <= 8'hFF;
      ca_s1_q       <= 7'h7F;
      ca_s2_q       <= 7'h7F;
      prev_q        <= 15'h7FFF;
      cnt_q         <= '0;
      latch_q       <= 1'b0;
      buf_q         <= 32'h0;
      mask_q        <= 8'h00;
      err_q         <= 8'h00;
      digits_q      <= 32'h0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      an_s1_q       <= anode;
      an_s2_q       <= an_s1_q;
      ca_s1_q       <= cathode;
      ca_s2_q       <= ca_s1_q;
      prev_q        <= {an_s2_q, ca_s2_q};
      cnt_q         <= cnt_d;
      latch_q       <= latch_d;
      buf_q         <= buf_d;
      mask_q        <= mask_d;
      err_q         <= err_d;
      frame_valid_q <= w_full;
      if (w_full) begin
        digits_q    <= buf_q;
        frame_err_q <= |err_q;
      end
    end
  end

  assign digits      = digits_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;

`ifdef SEG_SCAN_ROT_DETECT_EN
  logic have_prev_q;
  logic rotated_q;

  // digits_q still holds the previous frame at the load edge, so it serves as prev_digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      have_prev_q <= 1'b0;
      rotated_q   <= 1'b0;
    end else begin
      rotated_q <= 1'b0;
      if (w_full) begin
        have_prev_q <= 1'b1;
        rotated_q   <= have_prev_q && !(|err_q) && !frame_err_q &&
                       (buf_q == {digits_q[3:0], digits_q[31:4]});
      end
    end
  end

  assign rotated = rotated_q;
`else
  assign rotated = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
// +--------------------------------------------------------------------------+
// | tb_seg_scan_decoder: directed scan bench with a frame-level reference.    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_seg_scan_decoder;

  localparam int S    = 16;
  localparam int HOLD = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  anode = 8'hFF;
  logic [6:0]  cathode = 7'h7F;
  logic [31:0] digits;
  logic        frame_valid;
  logic        frame_err;
  logic        rotated;

  seg_scan_decoder #(.STABLE_CYC(S), .CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .anode       (anode),
    .cathode     (cathode),
    .digits      (digits),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .rotated     (rotated)
  );

  always #5 clk = ~clk;

  // Active-high g..a shapes for hex 0..F.
  logic [6:0] shape [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_fv  = 0;
  int n_rot = 0;

  typedef struct {
    int         idx;
    logic [3:0] nib;
    logic       err;
  } cap_t;
  cap_t cap_q [int];

  logic [3:0]  m_buf [8];
  logic [7:0]  m_err  = 8'h00;
  logic [7:0]  m_seen = 8'h00;
  logic [31:0] e_dig  = 32'h0;
  logic        e_fv   = 1'b0;
  logic        e_err  = 1'b0;
  logic        e_rot  = 1'b0;
  logic        have_prev = 1'b0;

  function automatic logic [4:0] dec(input logic [6:0] p);
    for (int v = 0; v < 16; v++) begin
      if (shape[v] == p) return {1'b0, 4'(v)};
    end
    return 5'h10;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Frame-level reference: a frame is emitted one cycle after all eight digits are seen.
  always @(posedge clk) begin : model
    logic [31:0] nw;
    logic        ne;
    cap_t        c;
    cyc++;
    if (!rst_n) begin
      cap_q.delete();
      m_seen = 8'h00; m_err = 8'h00;
      e_dig = 32'h0; e_fv = 1'b0; e_err = 1'b0; e_rot = 1'b0; have_prev = 1'b0;
      for (int i = 0; i < 8; i++) m_buf[i] = 4'h0;
    end else begin
      e_fv  = 1'b0;
      e_rot = 1'b0;
      if (m_seen == 8'hFF) begin
        for (int i = 0; i < 8; i++) nw[4*i +: 4] = m_buf[i];
        ne = |m_err;
`ifdef SEG_SCAN_ROT_DETECT_EN
        e_rot = have_prev && !ne && !e_err && (nw == {e_dig[3:0], e_dig[31:4]});
`endif
        e_dig = nw; e_err = ne; e_fv = 1'b1; have_prev = 1'b1;
        m_seen = 8'h00; m_err = 8'h00;
      end
      if (cap_q.exists(cyc)) begin
        c = cap_q[cyc];
        m_buf[c.idx]  = c.nib;
        m_err[c.idx]  = c.err;
        m_seen[c.idx] = 1'b1;
        cap_q.delete(cyc);
      end
    end
  end

  always @(negedge clk) begin : compare
    if (!rst_n) chk("outputs_in_reset", {digits, frame_valid, frame_err, rotated}, 64'h0);
    else chk("outputs", {digits, frame_valid, frame_err, rotated},
             {e_dig, e_fv, e_err, e_rot});
    n_fv  += int'(frame_valid);
    n_rot += int'(rotated);
  end

  // Drive one slot; a slot held past the sync + stability window is captured S+3 edges later.
  task automatic slot(input int idx, input logic [6:0] pat, input int hold);
    logic [4:0] d;
    @(posedge clk); #1;
    anode   = ~(8'(1) << idx);
    cathode = ~pat;
    if (hold >= S + 1) begin
      d = dec(pat);
      cap_q[cyc + S + 3] = '{idx: idx, nib: d[3:0], err: d[4]};
    end
    repeat (hold - 1) @(posedge clk);
  endtask

  task automatic scan(input logic [31:0] val, input int start, input int n,
                      input int short_idx, input int blank_idx);
    int i;
    for (int k = 0; k < n; k++) begin
      i = (start + k) % 8;
      slot(i, (i == blank_idx) ? 7'h00 : shape[val[4*i +: 4]],
           (i == short_idx) ? S - 1 : HOLD);
    end
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; anode = 8'hFF; cathode = 7'h7F;
    #1 chk("zero_during_reset", {digits, frame_valid, frame_err, rotated}, 64'h0);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin : stim
    int f0, r0;
    repeat (3) @(posedge clk);
    #1 chk("reset_state", {digits, frame_valid, frame_err, rotated}, 64'h0);
    rst_n = 1'b1;

    f0 = n_fv;
    scan(32'h24646421, 0, 8, -1, -1);
    chk("t1_frames", n_fv - f0, 1);
    chk("t1_digits", digits, 32'h24646421);
    chk("t1_err", frame_err, 0);

    f0 = n_fv; r0 = n_rot;
    scan(32'h24646421, 5, 8, -1, -1);
    chk("t2_frames", n_fv - f0, 1);
    chk("t2_digits", digits, 32'h24646421);
    chk("t2_rot", n_rot - r0, 0);

    do_reset();
    f0 = n_fv;
    scan(32'h24646421, 0, 8, 3, -1);
    chk("t3_short_frames", n_fv - f0, 0);
    scan(32'h24646421, 0, 8, -1, -1);
    chk("t3_full_frames", n_fv - f0, 1);
    chk("t3_digits", digits, 32'h24646421);

    do_reset();
    f0 = n_fv;
    scan(32'h24646421, 0, 8, -1, 2);
    chk("t4_frames", n_fv - f0, 1);
    chk("t4_digits", digits, 32'h24646021);
    chk("t4_err", frame_err, 1);

    do_reset();
    f0 = n_fv; r0 = n_rot;
    scan(32'h24646421, 0, 8, -1, -1);
    scan(32'h12464642, 0, 8, -1, -1);
    chk("t5_frames", n_fv - f0, 2);
    chk("t5_digits", digits, 32'h12464642);
`ifdef SEG_SCAN_ROT_DETECT_EN
    chk("t5_rot", n_rot - r0, 1);
`else
    chk("t5_rot", n_rot - r0, 0);
`endif

    scan(32'h24646421, 0, 5, -1, -1);
    do_reset();
    chk("t6_digits_cleared", digits, 32'h0);
    f0 = n_fv;
    scan(32'h24646421, 5, 7, -1, -1);
    chk("t6_partial_frames", n_fv - f0, 0);
    chk("t6_partial_digits", digits, 32'h0);
    scan(32'h24646421, 4, 1, -1, -1);
    chk("t6_frames", n_fv - f0, 1);
    chk("t6_digits", digits, 32'h24646421);

    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receive-side counterpart of the multiplexed 7-segment driver: it watches the anode/cathode scan lines a display multiplexer produces and reconstructs the eight 4-bit digit codes being shown. It sits on the board-loopback / self-test path, fed directly from the multiplexer outputs or from external pins. It emits a frame word each time all eight digit slots have been captured. An optional rotation detector flags when the new frame is the previous frame rotated by one nibble.

## Interface

Parameters:
- STABLE_CYC, 16: consecutive cycles a slot's anode+cathode must hold before capture (≥2).
- CNT_W, 8: width of the stability counter; must hold STABLE_CYC.

Ports:
- clk, input, 1: single clock; all state on rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- anode, input, 8: active-low one-hot digit select; anode[i]=0 selects digit i.
- cathode, input, 7: active-low segments, cathode[0]=a … cathode[6]=g.
- digits, output, 32: last complete frame; digit i in bits [4i+3:4i].
- frame_valid, output, 1: one-cycle pulse when digits updates.
- frame_err, output, 1: held with digits; 1 if any slot in that frame had an undecodable pattern.
- rotated, output, 1: one-cycle pulse coincident with frame_valid (see Configuration).

## Operation

- anode and cathode each pass through a 2-flop synchronizer; all logic uses the synchronized values.
- Slot tracking: the {anode,cathode} value from the previous cycle is held. Any change, or an anode that is not exactly one-low, resets the stability counter to 0 and clears the slot-captured latch.
- While the slot is valid and unchanged, the counter increments and saturates at STABLE_CYC. On the cycle it reaches STABLE_CYC, and the latch is clear, the slot is captured once: decode, write the nibble buffer entry for index i, set mask bit i and error bit i, set the latch.
- Decode table (active-high a–g shapes): 0 abcdef, 1 bc, 2 abdeg, 3 abcdg, 4 bcfg, 5 acdfg, 6 acdefg, 7 abc, 8 abcdefg, 9 abcdfg, A abcefg, b cdefg, C adef, d bcdeg, E adefg, F aefg.
- Any other pattern, including blank, decodes to 4'h0 and sets error bit i.
- Re-capture of a digit already in the mask overwrites its nibble and error bit; the mask is unchanged.
- Frame complete when mask == 8'hFF. Next cycle: digits ← buffer, frame_err ← OR of error bits, frame_valid=1, mask and error bits cleared. Capture order is irrelevant, so a scan starting mid-sequence is accepted.
- A capture on the same cycle as a frame load goes into the cleared mask; the new frame's first bit is not lost.

## Timing

- Reset values: digits=0, frame_valid=0, frame_err=0, rotated=0, mask=0, counter=0, latch=0, synchronizers all-ones (idle, active-low).
- Pin-to-capture latency: 2 sync cycles + STABLE_CYC cycles of stable input after the change.
- Capture to frame_valid: 1 cycle.
- Reset asserted mid-frame discards the partial mask and buffer.
- Anode all-high (blanking gap) or multi-low: no capture, counter held at 0.

## Configuration

- SEG_SCAN_ROT_DETECT_EN defined: keep prev_digits, updated on each frame load. rotated=1 with frame_valid when new == {prev[3:0],prev[31:4]} and the previous frame exists (at least one frame since reset). frame_err on either frame suppresses rotated.
- Not defined: no prev_digits register; rotated tied to 0.

## Test plan

- Scan digit i with nibble values 1,2,4,6,4,6,4,2 (i=0..7), each slot held 40 cycles → one frame_valid, digits=32'h24646421, frame_err=0.
- Same scan starting at digit 5 and wrapping to 4 → identical digits, exactly one pulse per 8 slots.
- Slot 3 held only STABLE_CYC-1 cycles per pass → no frame_valid for that pass. Later full-length passes → frame produced.
- Slot 2 drives blank 7'h7F → digits[11:8]=0, frame_err=1.
- With macro: frames 32'h24646421 then 32'h12464642 → rotated pulses on the second. Without macro: rotated stays 0.
- rst_n pulled low after 5 captured slots, then released → no frame until 8 fresh captures, all outputs 0 during reset.
